sample_framer: RTL and testbench

SAMPLE_FRAMER -- requirements
Module: sample_framer

---
 rtl/sample_framer.sv | 131 +++++++++++++
 tb/tb_sample_framer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_framer.sv
// Buffers one SPI-framed burst of 8-bit audio samples for a downstream processor; registered reads (1 cycle).
// Optional frame-energy accumulator enabled by SAMPLE_ENERGY_EN; samples arriving outside a fill are dropped and flagged.
module sample_framer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ss,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              frame_ready,
   output logic [AW:0]       count,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   input  logic              frame_done,
   output logic              overflow,
   output logic [8+AW-1:0]   energy
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY} state_t;

   localparam logic [AW:0] C_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   state_t        r_state;
   state_t        w_next;
   logic          r_ss_meta;
   logic          r_ss_sync;
   logic          r_ss_prev;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          r_rd_valid;
   logic [7:0]    r_rd_data;
   logic [7:0]    r_mem [DEPTH];

   logic          w_ss_rise;
   logic          w_ss_fall;
   logic          w_wr;
   logic          w_start;

   assign w_ss_rise = r_ss_sync & ~r_ss_prev;
   assign w_ss_fall = ~r_ss_sync & r_ss_prev;
   assign w_start   = (r_state == S_IDLE) && w_ss_rise;
   assign w_wr      = (r_state == S_FILL) && in_valid && (r_count != C_FULL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ss_meta <= 1'b0;
         r_ss_sync <= 1'b0;
         r_ss_prev <= 1'b0;
      end else begin
         r_ss_meta <= ss;
         r_ss_sync <= r_ss_meta;
         r_ss_prev <= r_ss_sync;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_ss_rise) w_next = S_FILL;
         S_FILL: begin
            // A write landing in the same cycle as the ss fall still counts toward the frame.
            if (w_wr && (r_count == C_LAST))
               w_next = S_READY;
            else if (w_ss_fall)
               w_next = ((r_count != '0) || w_wr) ? S_READY : S_IDLE;
         end
         S_READY: if (frame_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_start)   r_count <= '0;
         else if (w_wr) r_count <= r_count + 1'b1;
         if (in_valid && !w_wr) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_count[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= 8'h00;
      end else begin
         r_rd_valid <= (r_state == S_READY) && rd_en;
         if ((r_state == S_READY) && rd_en)
            r_rd_data <= ({1'b0, rd_addr} < r_count) ? r_mem[rd_addr] : 8'h00;
      end
   end

`ifdef SAMPLE_ENERGY_EN
   logic [7:0]      w_mag;
   logic [8+AW-1:0] r_energy;

   assign w_mag = in_data[7] ? (in_data - 8'h80) : (8'h80 - in_data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_energy <= '0;
      else if (w_start) r_energy <= '0;
      else if (w_wr)    r_energy <= r_energy + (8+AW)'(w_mag);
   end

   assign energy = r_energy;
`else
   assign energy = '0;
`endif

   assign frame_ready = (r_state == S_READY);
   assign count       = r_count;
   assign overflow    = r_overflow;
   assign rd_valid    = r_rd_valid;
   assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer: a cycle-vector table plus hand-written multi-cycle sequences.
module tb_sample_framer;

   logic        clk = 1'b0;
   logic        reset;
   logic        ss;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        frame_ready;
   logic [4:0]  count;
   logic        rd_en;
   logic [3:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        frame_done;
   logic        overflow;
   logic [11:0] energy;

   int n_chk  = 0;
   int n_pass = 0;

`ifdef SAMPLE_ENERGY_EN
   localparam bit EN_ON = 1'b1;
`else
   localparam bit EN_ON = 1'b0;
`endif

   sample_framer #(.DEPTH(16), .AW(4)) dut (
      .clk(clk), .reset(reset), .ss(ss), .in_valid(in_valid), .in_data(in_data),
      .frame_ready(frame_ready), .count(count), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done),
      .overflow(overflow), .energy(energy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ss;
      logic       vld;
      logic [7:0] dat;
      logic       rde;
      logic [3:0] addr;
      logic       done;
      logic       fr;
      logic [4:0] cnt;
      logic       rv;
      logic [7:0] rd;
      logic       ovf;
      int         en;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [11:0] en_exp(input int v);
      return EN_ON ? 12'(v) : 12'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic add(input int s, input int v, input int d, input int re, input int a, input int dn,
                      input int fr, input int c, input int rv, input int rd, input int ov, input int e);
      vec_t x;
      x.ss = 1'(s); x.vld = 1'(v); x.dat = 8'(d); x.rde = 1'(re); x.addr = 4'(a); x.done = 1'(dn);
      x.fr = 1'(fr); x.cnt = 5'(c); x.rv = 1'(rv); x.rd = 8'(rd); x.ovf = 1'(ov); x.en = e;
      tbl.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_data = 8'h00; rd_en = 1'b0; rd_addr = 4'd0; frame_done = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      ss    = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic strobe(input logic [7:0] d);
      in_valid = 1'b1; in_data = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic read(input logic [3:0] a);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " fr"},  32'(frame_ready), 32'd0);
      chk({tag, " cnt"}, 32'(count),       32'd0);
      chk({tag, " rv"},  32'(rd_valid),    32'd0);
      chk({tag, " rd"},  32'(rd_data),     32'd0);
      chk({tag, " ovf"}, 32'(overflow),    32'd0);
      chk({tag, " en"},  32'(energy),      32'd0);
   endtask

   initial begin
      // ss rise then fall with no strobes, then 3-sample frame closed by ss, then drop + release
      //  ss vld dat  rde adr dn | fr cnt rv rd   ovf energy
      add(1, 0, 0,    0, 0, 0,   0, 0, 0, 0,    0, 0);
      add(1, 0, 0,    0, 0, 0,   0, 0, 0, 0,    0, 0);
      add(0, 0, 0,    0, 0, 0,   0, 0, 0, 0,    0, 0);
      add(0, 0, 0,    0, 0, 0,   0, 0, 0, 0,    0, 0);
      add(0, 0, 0,    0, 0, 0,   0, 0, 0, 0,    0, 0);
      add(1, 0, 0,    0, 0, 0,   0, 0, 0, 0,    0, 0);
      add(1, 0, 0,    0, 0, 0,   0, 0, 0, 0,    0, 0);
      add(1, 0, 0,    0, 0, 0,   0, 0, 0, 0,    0, 0);
      add(1, 1, 'h90, 0, 0, 0,   0, 1, 0, 0,    0, 16);
      add(1, 1, 'h70, 0, 0, 0,   0, 2, 0, 0,    0, 32);
      add(1, 1, 'h80, 0, 0, 0,   0, 3, 0, 0,    0, 32);
      add(0, 0, 0,    0, 0, 0,   0, 3, 0, 0,    0, 32);
      add(0, 0, 0,    0, 0, 0,   0, 3, 0, 0,    0, 32);
      add(0, 0, 0,    0, 0, 0,   1, 3, 0, 0,    0, 32);
      add(0, 0, 0,    1, 7, 0,   1, 3, 1, 'h00, 0, 32);
      add(0, 0, 0,    1, 0, 0,   1, 3, 1, 'h90, 0, 32);
      add(0, 0, 0,    1, 2, 0,   1, 3, 1, 'h80, 0, 32);
      add(0, 0, 0,    0, 0, 0,   1, 3, 0, 0,    0, 32);
      add(0, 1, 'h55, 0, 0, 0,   1, 3, 0, 0,    1, 32);
      add(0, 0, 0,    1, 1, 0,   1, 3, 1, 'h70, 1, 32);
      add(0, 0, 0,    1, 3, 0,   1, 3, 1, 'h00, 1, 32);
      add(0, 0, 0,    0, 0, 1,   0, 3, 0, 0,    1, 32);
      add(0, 0, 0,    1, 0, 0,   0, 3, 0, 0,    1, 32);
      add(1, 0, 0,    0, 0, 1,   0, 3, 0, 0,    1, 32);

      idle_inputs();
      ss    = 1'b0;
      reset = 1'b1;
      #2;
      chk_reset_outputs("por");
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk_reset_outputs("post_rst");

      for (int i = 0; i < tbl.size(); i++) begin
         ss = tbl[i].ss; in_valid = tbl[i].vld; in_data = tbl[i].dat;
         rd_en = tbl[i].rde; rd_addr = tbl[i].addr; frame_done = tbl[i].done;
         tick();
         chk($sformatf("v%0d fr", i),  32'(frame_ready), 32'(tbl[i].fr));
         chk($sformatf("v%0d cnt", i), 32'(count),       32'(tbl[i].cnt));
         chk($sformatf("v%0d rv", i),  32'(rd_valid),    32'(tbl[i].rv));
         chk($sformatf("v%0d ovf", i), 32'(overflow),    32'(tbl[i].ovf));
         chk($sformatf("v%0d en", i),  32'(energy),      32'(en_exp(tbl[i].en)));
         if (tbl[i].rv) chk($sformatf("v%0d rd", i), 32'(rd_data), 32'(tbl[i].rd));
      end
      idle_inputs();

      // full 16-sample frame, saturation, ss rise ignored in READY, release
      do_reset();
      ss = 1'b1;
      tick(); tick(); tick();
      for (int i = 0; i < 16; i++) begin
         strobe(8'(i));
         if (i == 14) begin
            chk("full15 fr",  32'(frame_ready), 32'd0);
            chk("full15 cnt", 32'(count),       32'd15);
         end
      end
      chk("full fr",  32'(frame_ready), 32'd1);
      chk("full cnt", 32'(count),       32'd16);
      chk("full en",  32'(energy),      32'(en_exp(1928)));
      read(4'd5);
      chk("full rd5 rv", 32'(rd_valid), 32'd1);
      chk("full rd5",    32'(rd_data),  32'h05);
      read(4'd15);
      chk("full rd15", 32'(rd_data), 32'h0F);
      strobe(8'hEE);
      chk("sat cnt", 32'(count),    32'd16);
      chk("sat ovf", 32'(overflow), 32'd1);
      ss = 1'b0;
      tick(); tick(); tick();
      ss = 1'b1;
      tick(); tick(); tick(); tick();
      chk("rerise fr",  32'(frame_ready), 32'd1);
      chk("rerise cnt", 32'(count),       32'd16);
      read(4'd3);
      chk("rerise rd3", 32'(rd_data), 32'h03);
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      chk("done fr",  32'(frame_ready), 32'd0);
      chk("done cnt", 32'(count),       32'd16);

      // overflow in IDLE, then reset mid-fill
      do_reset();
      strobe(8'h11);
      chk("idle ovf", 32'(overflow), 32'd1);
      chk("idle cnt", 32'(count),    32'd0);
      ss = 1'b1;
      tick(); tick(); tick();
      for (int i = 0; i < 8; i++) strobe(8'hC0);
      chk("mid cnt", 32'(count),  32'd8);
      chk("mid en",  32'(energy), 32'(en_exp(512)));
      ss    = 1'b0;
      reset = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      tick();
      reset = 1'b0;
      tick(); tick();
      ss = 1'b1;
      tick(); tick(); tick();
      chk("restart cnt", 32'(count), 32'd0);
      chk("restart fr",  32'(frame_ready), 32'd0);
      strobe(8'h42);
      chk("restart cnt1", 32'(count), 32'd1);

      // 16th strobe coincides with synchronized ss fall
      do_reset();
      ss = 1'b1;
      tick(); tick(); tick();
      for (int i = 0; i < 16; i++) begin
         if (i >= 13) ss = 1'b0;
         strobe(8'(8'hA0 + i));
         if (i == 14) chk("coinc15 fr", 32'(frame_ready), 32'd0);
      end
      chk("coinc fr",  32'(frame_ready), 32'd1);
      chk("coinc cnt", 32'(count),       32'd16);
      chk("coinc en",  32'(energy),      32'(en_exp(632)));
      read(4'd15);
      chk("coinc rd15 rv", 32'(rd_valid), 32'd1);
      chk("coinc rd15",    32'(rd_data),  32'hAF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
